// File: rtl/adaptive_binarizer.sv
// -----------------------------------------------------------------------------
// adaptive_binarizer
//   Frame scanner/comparator that sits after the pixel ROM and threshold_rom.
//   A single shared read address walks the frame in row-major order. Each
//   returned pixel is compared with its local threshold, and the 1-bit result
//   goes out on a valid/ready stream together with its x/y coordinates.
//
//   At most two pixels are ever buffered or in flight. Because of that, no
//   pixel is dropped or duplicated, whatever pattern out_ready_i follows.
//
// Optional feature (compile-time macro):
//   BINARIZE_OFFSET_EN  effective threshold = max(thr - OFFSET, 0);
//                       when undefined the raw threshold is used.
//
// Ports
//   clock_i      clock, all logic on posedge
//   reset_i      synchronous, active-high reset
//   start_i      begin a frame (only looked at in IDLE)
//   busy_o       high while scanning or draining
//   done_o       one-cycle pulse at frame end
//   rom_addr_o   shared read address to both ROMs (1-cycle sync read)
//   pix_q_i      pixel ROM data
//   thr_q_i      threshold ROM data
//   out_valid_o  output stream valid
//   out_ready_i  output stream ready
//   out_bit_o    1 = pixel above effective threshold
//   out_x_o      column of out_bit_o
//   out_y_o      row of out_bit_o
//   out_last_o   final pixel of the frame
// -----------------------------------------------------------------------------
module adaptive_binarizer #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int OFFSET = 4
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [ADDR_W-1:0]         rom_addr_o,
  input  logic [DATA_W-1:0]         pix_q_i,
  input  logic [DATA_W-1:0]         thr_q_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      out_bit_o,
  output logic [$clog2(IMG_W)-1:0]  out_x_o,
  output logic [$clog2(IMG_H)-1:0]  out_y_o,
  output logic                      out_last_o
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  // Reject configurations whose frame cannot be addressed.
  if ((IMG_W * IMG_H) > (2 ** ADDR_W) || OFFSET < 0) begin : g_bad_cfg
    $error("adaptive_binarizer: invalid IMG_W/IMG_H/ADDR_W/OFFSET");
  end

  // state   | meaning
  // S_IDLE  | waiting for start_i, address parked at 0
  // S_RUN   | issuing reads, one per cycle when buffer space allows
  // S_DRAIN | last address issued, emptying buffer and in-flight read
  // S_DONE  | one-cycle done pulse, then back to idle
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e state_q, state_d;

  // Coordinates and address of the next pixel to be issued
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;

  // Read in flight: metadata travels alongside the 1-cycle ROM latency
  logic              inflight_q, inflight_d;
  logic [XW-1:0]     if_x_q;
  logic [YW-1:0]     if_y_q;
  logic              if_last_q;

  // 2-entry output FIFO
  logic [1:0]        fifo_bit_q;
  logic [XW-1:0]     fifo_x_q [2];
  logic [YW-1:0]     fifo_y_q [2];
  logic [1:0]        fifo_last_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;

  logic              push, pop, issue, issue_last, pix_gt;
  logic [DATA_W-1:0] eff_thr;

`ifdef BINARIZE_OFFSET_EN
  // Extra bit catches the borrow so the threshold saturates at zero.
  logic [DATA_W:0] thr_diff;
  assign thr_diff = {1'b0, thr_q_i} - (DATA_W+1)'(OFFSET);
  assign eff_thr  = thr_diff[DATA_W] ? '0 : thr_diff[DATA_W-1:0];
`else
  assign eff_thr  = thr_q_i;
`endif

  assign pix_gt      = pix_q_i > eff_thr;

  assign out_valid_o = (count_q != 2'd0);
  assign pop         = out_valid_o & out_ready_i;
  assign push        = inflight_q;
  assign count_d     = count_q + {1'b0, push} - {1'b0, pop};

  // Keep buffered plus outstanding pixels at or below two, counting the
  // slot freed by a pop in this same cycle.
  assign issue       = (state_q == S_RUN) &&
                       (({1'b0, count_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
  assign issue_last  = (x_q == X_MAX) && (y_q == Y_MAX);
  assign inflight_d  = issue;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (issue) begin
          if (issue_last) begin
            // Address stays on the final pixel until the frame completes.
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (x_q == X_MAX) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      S_DRAIN: begin
        // No issues here, so an empty FIFO next cycle means nothing is left.
        if (count_d == 2'd0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = '0;
        x_d     = '0;
        y_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      inflight_q  <= 1'b0;
      if_x_q      <= '0;
      if_y_q      <= '0;
      if_last_q   <= 1'b0;
      fifo_bit_q  <= '0;
      fifo_x_q[0] <= '0;
      fifo_x_q[1] <= '0;
      fifo_y_q[0] <= '0;
      fifo_y_q[1] <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (issue) begin
        if_x_q    <= x_q;
        if_y_q    <= y_q;
        if_last_q <= issue_last;
      end
      if (push) begin
        fifo_bit_q[wr_ptr_q]  <= pix_gt;
        fifo_x_q[wr_ptr_q]    <= if_x_q;
        fifo_y_q[wr_ptr_q]    <= if_y_q;
        fifo_last_q[wr_ptr_q] <= if_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o     = (state_q == S_DONE);
  assign rom_addr_o = addr_q;

  // Head entry drives the stream; outputs read as zero while empty.
  assign out_bit_o  = out_valid_o & fifo_bit_q[rd_ptr_q];
  assign out_x_o    = out_valid_o ? fifo_x_q[rd_ptr_q] : '0;
  assign out_y_o    = out_valid_o ? fifo_y_q[rd_ptr_q] : '0;
  assign out_last_o = out_valid_o & fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_adaptive_binarizer.sv
module tb_adaptive_binarizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Small 4x2 instance
  logic        rst_s, start_s, busy_s, done_s, valid_s, ready_s, bit_s, last_s;
  logic [15:0] addr_s;
  logic [7:0]  pix_s, thr_s;
  logic [1:0]  x_s;
  logic [0:0]  y_s;
  logic [7:0]  pix_mem_s [8];
  logic [7:0]  thr_mem_s [8];

  // Full-size 256x256 instance
  logic        rst_l, start_l, busy_l, done_l, valid_l, ready_l, bit_l, last_l;
  logic [15:0] addr_l;
  logic [7:0]  pix_l, thr_l;
  logic [7:0]  x_l, y_l;
  logic [7:0]  pix_mem_l [65536];
  logic [7:0]  thr_mem_l [65536];

  adaptive_binarizer #(.IMG_W(4), .IMG_H(2), .ADDR_W(16), .DATA_W(8), .OFFSET(4)) dut_s (
    .clock_i(clk), .reset_i(rst_s), .start_i(start_s), .busy_o(busy_s), .done_o(done_s),
    .rom_addr_o(addr_s), .pix_q_i(pix_s), .thr_q_i(thr_s), .out_valid_o(valid_s),
    .out_ready_i(ready_s), .out_bit_o(bit_s), .out_x_o(x_s), .out_y_o(y_s), .out_last_o(last_s)
  );

  adaptive_binarizer #(.IMG_W(256), .IMG_H(256), .ADDR_W(16), .DATA_W(8), .OFFSET(4)) dut_l (
    .clock_i(clk), .reset_i(rst_l), .start_i(start_l), .busy_o(busy_l), .done_o(done_l),
    .rom_addr_o(addr_l), .pix_q_i(pix_l), .thr_q_i(thr_l), .out_valid_o(valid_l),
    .out_ready_i(ready_l), .out_bit_o(bit_l), .out_x_o(x_l), .out_y_o(y_l), .out_last_o(last_l)
  );

  // Synchronous-read ROM models
  always @(posedge clk) begin
    pix_s <= pix_mem_s[addr_s[2:0]];
    thr_s <= thr_mem_s[addr_s[2:0]];
    pix_l <= pix_mem_l[addr_l];
    thr_l <= thr_mem_l[addr_l];
  end

  // Reference comparison from plain integer arithmetic
  function automatic logic model_bit(input int pix, input int thr);
    int eff;
`ifdef BINARIZE_OFFSET_EN
    eff = thr - 4;
    if (eff < 0) eff = 0;
`else
    eff = thr;
`endif
    return pix > eff;
  endfunction

  // Runs one 4x2 frame. mode 0: ready always 1; 1: stall 5 cycles after the
  // 2nd pixel then toggle; 2: random ready.
  task automatic run_small(input int mode, input string name);
    int idx, first_k, last_k, done_cnt, hold, outstanding;
    logic prev_stall, rdy;
    logic p_bit, p_last;
    logic [1:0] p_x;
    logic [0:0] p_y;
    logic e_bit, e_last;
    logic [1:0] e_x;
    logic [0:0] e_y;
    idx = 0; first_k = -1; last_k = -1; done_cnt = 0; hold = 0;
    prev_stall = 1'b0;
    p_bit = 1'b0; p_last = 1'b0; p_x = '0; p_y = '0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (last_k >= 0 && k > last_k + 3) break;
      if (k == 0) begin
        vectors++;
        if (busy_s !== 1'b1)
          begin miscompares++; $display("FAIL %s busy_after_start: got %0b expected 1", name, busy_s); end
      end
      if (prev_stall) begin
        vectors++;
        if ({valid_s, bit_s, x_s, y_s, last_s} !== {1'b1, p_bit, p_x, p_y, p_last}) begin
          miscompares++;
          $display("FAIL %s stall_hold k=%0d: got v=%0b bit=%0b x=%0d y=%0d last=%0b expected v=1 bit=%0b x=%0d y=%0d last=%0b",
                   name, k, valid_s, bit_s, x_s, y_s, last_s, p_bit, p_x, p_y, p_last);
        end
      end
      if (done_s) begin
        done_cnt++;
        vectors++;
        if (k != last_k + 1)
          begin miscompares++; $display("FAIL %s done_timing: got cycle %0d expected %0d", name, k, last_k + 1); end
      end
      outstanding = int'(addr_s) - idx;
      vectors++;
      if (outstanding > 2)
        begin miscompares++; $display("FAIL %s outstanding k=%0d: got %0d expected <=2", name, k, outstanding); end
      case (mode)
        0: rdy = 1'b1;
        1: begin
          if (idx < 2) rdy = 1'b1;
          else if (hold < 5) begin rdy = 1'b0; hold++; end
          else rdy = k[0];
        end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ready_s = rdy;
      if (valid_s && first_k < 0) first_k = k;
      if (valid_s && rdy) begin
        vectors++;
        if (idx >= 8) begin
          miscompares++;
          $display("FAIL %s extra_pixel: got pixel %0d expected none", name, idx);
        end else begin
          e_bit  = model_bit(int'(pix_mem_s[idx]), int'(thr_mem_s[idx]));
          e_x    = 2'(idx % 4);
          e_y    = 1'(idx / 4);
          e_last = (idx == 7);
          if ({bit_s, x_s, y_s, last_s} !== {e_bit, e_x, e_y, e_last}) begin
            miscompares++;
            $display("FAIL %s pixel %0d: got bit=%0b x=%0d y=%0d last=%0b expected bit=%0b x=%0d y=%0d last=%0b",
                     name, idx, bit_s, x_s, y_s, last_s, e_bit, e_x, e_y, e_last);
          end
        end
        if (last_s) last_k = k;
        idx++;
      end
      prev_stall = valid_s && !rdy;
      p_bit = bit_s; p_x = x_s; p_y = y_s; p_last = last_s;
      @(negedge clk);
    end
    ready_s = 1'b1;
    vectors++;
    if (idx != 8) begin miscompares++; $display("FAIL %s pixel_count: got %0d expected 8", name, idx); end
    vectors++;
    if (done_cnt != 1) begin miscompares++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt); end
    vectors++;
    if (first_k != 2) begin miscompares++; $display("FAIL %s first_valid_latency: got %0d expected 2", name, first_k); end
    vectors++;
    if ({busy_s, valid_s, done_s, addr_s} !== {3'b000, 16'd0})
      begin miscompares++; $display("FAIL %s idle_after_frame: got busy=%0b valid=%0b done=%0b addr=%0d expected 0", name, busy_s, valid_s, done_s, addr_s); end
  endtask

  task automatic test_reset;
    vectors++;
    if ({addr_s, busy_s, done_s, valid_s, bit_s, x_s, y_s, last_s} !== '0)
      begin miscompares++; $display("FAIL reset_small: got addr=%0d busy=%0b done=%0b valid=%0b expected all 0", addr_s, busy_s, done_s, valid_s); end
    vectors++;
    if ({addr_l, busy_l, done_l, valid_l, bit_l, x_l, y_l, last_l} !== '0)
      begin miscompares++; $display("FAIL reset_large: got addr=%0d busy=%0b done=%0b valid=%0b expected all 0", addr_l, busy_l, done_l, valid_l); end
  endtask

  task automatic test_basic_frame;
    for (int i = 0; i < 8; i++) begin
      pix_mem_s[i] = 8'(i * 16);
      thr_mem_s[i] = 8'h40;
    end
    run_small(0, "basic");
  endtask

  task automatic test_stall;
    run_small(1, "stall");
  endtask

  task automatic test_compare_boundary;
    pix_mem_s[0] = 8'h80; thr_mem_s[0] = 8'h80;
    pix_mem_s[1] = 8'h81; thr_mem_s[1] = 8'h80;
    pix_mem_s[2] = 8'h7D; thr_mem_s[2] = 8'h80;
    pix_mem_s[3] = 8'h00; thr_mem_s[3] = 8'h02;
    pix_mem_s[4] = 8'hFF; thr_mem_s[4] = 8'hFF;
    pix_mem_s[5] = 8'hFF; thr_mem_s[5] = 8'h00;
    pix_mem_s[6] = 8'h00; thr_mem_s[6] = 8'hFF;
    pix_mem_s[7] = 8'h04; thr_mem_s[7] = 8'h03;
    run_small(2, "boundary");
  endtask

  task automatic test_random_frames;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) begin
        pix_mem_s[i] = 8'($urandom);
        thr_mem_s[i] = 8'($urandom);
      end
      run_small(2, "random");
    end
  endtask

  task automatic test_reset_midframe;
    int hs;
    for (int i = 0; i < 8; i++) begin
      pix_mem_s[i] = 8'($urandom);
      thr_mem_s[i] = 8'($urandom);
    end
    ready_s = 1'b1;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    hs = 0;
    for (int k = 0; k < 50 && hs < 3; k++) begin
      if (valid_s) hs++;
      @(negedge clk);
    end
    vectors++;
    if (hs != 3) begin miscompares++; $display("FAIL midreset_handshakes: got %0d expected 3", hs); end
    rst_s = 1'b1;
    @(negedge clk);
    vectors++;
    if ({valid_s, busy_s, done_s, addr_s} !== {3'b000, 16'd0})
      begin miscompares++; $display("FAIL midreset_abort: got valid=%0b busy=%0b done=%0b addr=%0d expected 0", valid_s, busy_s, done_s, addr_s); end
    rst_s = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({valid_s, busy_s, done_s} !== 3'b000)
        begin miscompares++; $display("FAIL midreset_quiet k=%0d: got valid=%0b busy=%0b done=%0b expected 0", k, valid_s, busy_s, done_s); end
    end
    run_small(0, "restart");
  endtask

  task automatic test_full_frame;
    int idx, first_k, last_k, done_cnt;
    logic e_bit, e_last;
    logic [7:0] e_x, e_y;
    for (int i = 0; i < 65536; i++) begin
      pix_mem_l[i] = 8'($urandom);
      thr_mem_l[i] = 8'($urandom);
    end
    ready_l = 1'b1;
    start_l = 1'b1;
    @(negedge clk);
    start_l = 1'b0;
    idx = 0; first_k = -1; last_k = -1; done_cnt = 0;
    for (int k = 0; k < 70000; k++) begin
      if (last_k >= 0 && k > last_k + 3) break;
      start_l = (k == 30000);
      if (done_l) begin
        done_cnt++;
        vectors++;
        if (k != last_k + 1)
          begin miscompares++; $display("FAIL full done_timing: got cycle %0d expected %0d", k, last_k + 1); end
      end
      if (first_k >= 0 && last_k < 0) begin
        vectors++;
        if (!valid_l) begin miscompares++; $display("FAIL full gap k=%0d: got valid=0 expected 1", k); end
      end
      if (valid_l && first_k < 0) first_k = k;
      if (valid_l) begin
        vectors++;
        e_bit  = model_bit(int'(pix_mem_l[idx % 65536]), int'(thr_mem_l[idx % 65536]));
        e_x    = 8'(idx % 256);
        e_y    = 8'(idx / 256);
        e_last = (idx == 65535);
        if ({bit_l, x_l, y_l, last_l} !== {e_bit, e_x, e_y, e_last}) begin
          miscompares++;
          $display("FAIL full pixel %0d: got bit=%0b x=%0d y=%0d last=%0b expected bit=%0b x=%0d y=%0d last=%0b",
                   idx, bit_l, x_l, y_l, last_l, e_bit, e_x, e_y, e_last);
        end
        if (last_l) last_k = k;
        idx++;
      end
      @(negedge clk);
    end
    start_l = 1'b0;
    vectors++;
    if (idx != 65536) begin miscompares++; $display("FAIL full pixel_count: got %0d expected 65536", idx); end
    vectors++;
    if (done_cnt != 1) begin miscompares++; $display("FAIL full done_pulses: got %0d expected 1", done_cnt); end
    vectors++;
    if (first_k != 2) begin miscompares++; $display("FAIL full first_valid_latency: got %0d expected 2", first_k); end
  endtask

  initial begin
    rst_s = 1'b1; rst_l = 1'b1;
    start_s = 1'b0; start_l = 1'b0;
    ready_s = 1'b1; ready_l = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pix_mem_s[i] = '0;
      thr_mem_s[i] = '0;
    end
    for (int i = 0; i < 65536; i++) begin
      pix_mem_l[i] = '0;
      thr_mem_l[i] = '0;
    end
    repeat (3) @(negedge clk);
    test_reset;
    rst_s = 1'b0; rst_l = 1'b0;
    @(negedge clk);
    test_basic_frame;
    test_stall;
    test_compare_boundary;
    test_random_frames;
    test_reset_midframe;
    test_full_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
